// File: rtl/obi_arb_rr_3_to_1.sv
// Round-robin arbiter: three OBI masters onto one OBI slave, with an in-order read ID FIFO.
// Optional per-master stall counters are enabled with `define OBI_ARB_STALL_CNT_EN.
module obi_arb_rr_3_to_1 #(
    parameter int unsigned OUTSTANDING_DEPTH = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    input  logic        m2_req_i,
    output logic        m2_gnt_o,
    input  logic [31:0] m2_addr_i,
    input  logic        m2_we_i,
    input  logic [3:0]  m2_be_i,
    input  logic [31:0] m2_wdata_i,
    output logic        m2_rvalid_o,
    output logic [31:0] m2_rdata_o,
    output logic        shr_req_o,
    input  logic        shr_gnt_i,
    output logic [31:0] shr_addr_o,
    output logic        shr_we_o,
    output logic [3:0]  shr_be_o,
    output logic [31:0] shr_wdata_o,
    input  logic        shr_rvalid_i,
    input  logic [31:0] shr_rdata_i
`ifdef OBI_ARB_STALL_CNT_EN
    ,
    output logic [47:0] stall_cnt_o
`endif
);

    localparam int CW = $clog2(OUTSTANDING_DEPTH + 1);
    localparam int PW = (OUTSTANDING_DEPTH > 1) ? $clog2(OUTSTANDING_DEPTH) : 1;

    typedef logic [1:0] id_t;

    function automatic id_t next_id(input id_t id);
        return (id == 2'd2) ? 2'd0 : id + 2'd1;
    endfunction

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUTSTANDING_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    logic [2:0]       req_v, we_v, gnt_v, rvalid_v;
    logic [2:0][31:0] addr_v, wdata_v, rdata_v;
    logic [2:0][3:0]  be_v;

    assign req_v   = {m2_req_i, m1_req_i, m0_req_i};
    assign we_v    = {m2_we_i, m1_we_i, m0_we_i};
    assign addr_v  = {m2_addr_i, m1_addr_i, m0_addr_i};
    assign wdata_v = {m2_wdata_i, m1_wdata_i, m0_wdata_i};
    assign be_v    = {m2_be_i, m1_be_i, m0_be_i};

    id_t           rr_ptr_q, rr_ptr_d, sel_q, sel_d, sel, idx;
    logic          lock_q, lock_d, found, present, hs, push, pop, full;
    logic [2:0]    elig;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    id_t           id_mem [OUTSTANDING_DEPTH];
    id_t           head;

    assign full = (count_q == CW'(OUTSTANDING_DEPTH));
    assign elig = req_v & (we_v | {3{~full}});
    assign head = id_mem[rd_ptr_q];

    // A locked master keeps the slave port until its handshake, independent of FIFO state.
    always_comb begin
        sel   = rr_ptr_q;
        found = 1'b0;
        idx   = rr_ptr_q;
        for (int k = 0; k < 3; k++) begin
            if (!found && elig[idx]) begin
                sel   = idx;
                found = 1'b1;
            end
            idx = next_id(idx);
        end
        if (lock_q) begin
            sel     = sel_q;
            present = req_v[sel_q];
        end else begin
            present = found;
        end
    end

    assign shr_req_o   = present;
    assign shr_addr_o  = addr_v[sel];
    assign shr_we_o    = we_v[sel];
    assign shr_be_o    = be_v[sel];
    assign shr_wdata_o = wdata_v[sel];

    assign hs   = present & shr_gnt_i;
    assign push = hs & ~we_v[sel];
    assign pop  = shr_rvalid_i & (count_q != '0);

    always_comb begin
        gnt_v    = '0;
        rvalid_v = '0;
        rdata_v  = '0;
        if (hs) gnt_v[sel] = 1'b1;
        if (pop) begin
            rvalid_v[head] = 1'b1;
            rdata_v[head]  = shr_rdata_i;
        end
    end

    assign {m2_gnt_o, m1_gnt_o, m0_gnt_o}          = gnt_v;
    assign {m2_rvalid_o, m1_rvalid_o, m0_rvalid_o} = rvalid_v;
    assign m0_rdata_o = rdata_v[0];
    assign m1_rdata_o = rdata_v[1];
    assign m2_rdata_o = rdata_v[2];

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        lock_d   = lock_q;
        sel_d    = sel_q;
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (hs) begin
            rr_ptr_d = next_id(sel);
            lock_d   = 1'b0;
        end else if (present) begin
            lock_d = 1'b1;
            sel_d  = sel;
        end
        if (push && !pop) count_d = count_q + CW'(1);
        else if (pop && !push) count_d = count_q - CW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_ptr_q <= '0;
            lock_q   <= 1'b0;
            sel_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            lock_q   <= lock_d;
            sel_q    <= sel_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: ID storage is not reset; entries are only read while count_q says they are valid.
    always_ff @(posedge clk_i) begin
        if (push) id_mem[wr_ptr_q] <= sel;
    end

`ifdef OBI_ARB_STALL_CNT_EN
    logic [2:0][15:0] stall_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_q <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (req_v[i] && !gnt_v[i] && stall_q[i] != 16'hFFFF)
                    stall_q[i] <= stall_q[i] + 16'd1;
            end
        end
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_obi_arb_rr_3_to_1.sv
// Self-checking bench for obi_arb_rr_3_to_1: directed scenarios plus a randomized run
// against a queue-based model of the round-robin/ID-routing rules.
module tb_obi_arb_rr_3_to_1;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  req, we, gnt, rvalid;
    logic [31:0] addr [3];
    logic [31:0] wdata [3];
    logic [3:0]  be [3];
    logic [31:0] rdata [3];
    logic        shr_req, shr_gnt, shr_we, shr_rvalid;
    logic [31:0] shr_addr, shr_wdata, shr_rdata;
    logic [3:0]  shr_be;
`ifdef OBI_ARB_STALL_CNT_EN
    logic [47:0] stall_cnt;
`endif

    int n_pass = 0;
    int n_checks = 0;

    always #5 clk = ~clk;

    obi_arb_rr_3_to_1 #(.OUTSTANDING_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(req[0]), .m0_gnt_o(gnt[0]), .m0_addr_i(addr[0]), .m0_we_i(we[0]),
        .m0_be_i(be[0]), .m0_wdata_i(wdata[0]), .m0_rvalid_o(rvalid[0]), .m0_rdata_o(rdata[0]),
        .m1_req_i(req[1]), .m1_gnt_o(gnt[1]), .m1_addr_i(addr[1]), .m1_we_i(we[1]),
        .m1_be_i(be[1]), .m1_wdata_i(wdata[1]), .m1_rvalid_o(rvalid[1]), .m1_rdata_o(rdata[1]),
        .m2_req_i(req[2]), .m2_gnt_o(gnt[2]), .m2_addr_i(addr[2]), .m2_we_i(we[2]),
        .m2_be_i(be[2]), .m2_wdata_i(wdata[2]), .m2_rvalid_o(rvalid[2]), .m2_rdata_o(rdata[2]),
        .shr_req_o(shr_req), .shr_gnt_i(shr_gnt), .shr_addr_o(shr_addr), .shr_we_o(shr_we),
        .shr_be_o(shr_be), .shr_wdata_o(shr_wdata), .shr_rvalid_i(shr_rvalid),
        .shr_rdata_i(shr_rdata)
`ifdef OBI_ARB_STALL_CNT_EN
        , .stall_cnt_o(stall_cnt)
`endif
    );

    task automatic clear_inputs();
        req = '0;
        we  = '0;
        for (int i = 0; i < 3; i++) begin
            addr[i]  = 32'h1000_0000 * (i + 1) + 32'h40;
            wdata[i] = 32'h5A5A_0000 + i;
            be[i]    = 4'hF;
        end
        shr_gnt    = 1'b0;
        shr_rvalid = 1'b0;
        shr_rdata  = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        shr_rvalid = 1'b1;
        shr_rdata  = 32'hCAFE_F00D;
        @(negedge clk);
        #1;
        n_checks++;
        if (shr_req !== 1'b0) $display("FAIL reset_shr_req: got %b want 0", shr_req);
        else n_pass++;
        n_checks++;
        if (rvalid !== 3'b000) $display("FAIL reset_rvalid: got %b want 000", rvalid);
        else n_pass++;
        n_checks++;
        if ((rdata[0] | rdata[1] | rdata[2]) !== 32'h0)
            $display("FAIL reset_rdata: got %h/%h/%h want 0", rdata[0], rdata[1], rdata[2]);
        else n_pass++;
        n_checks++;
        if (shr_addr !== addr[0]) $display("FAIL reset_payload: got %h want %h", shr_addr, addr[0]);
        else n_pass++;
        rst = 1'b0;
        shr_rvalid = 1'b0;
        req[2] = 1'b1;
        shr_gnt = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 3'b100) $display("FAIL reset_first_gnt: got %b want 100", gnt);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_rotation();
        logic [2:0] exp_g, exp_rv;
        do_reset();
        for (int c = 0; c < 7; c++) begin
            req        = (c < 6) ? 3'b111 : 3'b000;
            shr_gnt    = (c < 6);
            shr_rvalid = (c > 0);
            shr_rdata  = 32'hA000_0000 + c;
            #1;
            exp_g = (c < 6) ? 3'(1 << (c % 3)) : 3'b000;
            n_checks++;
            if (gnt !== exp_g) $display("FAIL rot_gnt c%0d: got %b want %b", c, gnt, exp_g);
            else n_pass++;
            if (c < 6) begin
                n_checks++;
                if (shr_addr !== addr[c % 3])
                    $display("FAIL rot_addr c%0d: got %h want %h", c, shr_addr, addr[c % 3]);
                else n_pass++;
            end
            if (c > 0) begin
                exp_rv = 3'(1 << ((c - 1) % 3));
                n_checks++;
                if (rvalid !== exp_rv || rdata[(c - 1) % 3] !== shr_rdata)
                    $display("FAIL rot_resp c%0d: got %b/%h want %b/%h", c, rvalid,
                             rdata[(c - 1) % 3], exp_rv, shr_rdata);
                else n_pass++;
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

    task automatic test_lock();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            req     = {1'b0, 1'b1, c >= 1};
            shr_gnt = (c == 3);
            #1;
            n_checks++;
            if (shr_req !== 1'b1 || shr_addr !== addr[1])
                $display("FAIL lock_hold c%0d: got %b/%h want 1/%h", c, shr_req, shr_addr, addr[1]);
            else n_pass++;
            n_checks++;
            if (gnt !== ((c == 3) ? 3'b010 : 3'b000))
                $display("FAIL lock_gnt c%0d: got %b", c, gnt);
            else n_pass++;
            @(negedge clk);
        end
        req = 3'b001;
        #1;
        n_checks++;
        if (gnt !== 3'b001 || shr_addr !== addr[0])
            $display("FAIL lock_next: got %b/%h want 001/%h", gnt, shr_addr, addr[0]);
        else n_pass++;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_fifo_full();
        do_reset();
        req[0]  = 1'b1;
        shr_gnt = 1'b1;
        for (int c = 0; c < DEPTH; c++) begin
            #1;
            n_checks++;
            if (gnt !== 3'b001) $display("FAIL full_fill c%0d: got %b want 001", c, gnt);
            else n_pass++;
            @(negedge clk);
        end
        req[1] = 1'b1;
        we[1]  = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 3'b010 || shr_we !== 1'b1 || shr_addr !== addr[1])
            $display("FAIL full_write: got %b/%b/%h want 010/1/%h", gnt, shr_we, shr_addr, addr[1]);
        else n_pass++;
        @(negedge clk);
        req[1] = 1'b0;
        #1;
        n_checks++;
        if (shr_req !== 1'b0 || gnt !== 3'b000 || shr_addr !== addr[2])
            $display("FAIL full_block: got %b/%b/%h want 0/000/%h", shr_req, gnt, shr_addr, addr[2]);
        else n_pass++;
        @(negedge clk);
        shr_rvalid = 1'b1;
        #1;
        n_checks++;
        if (rvalid !== 3'b001 || shr_req !== 1'b0)
            $display("FAIL full_pop: got %b/%b want 001/0", rvalid, shr_req);
        else n_pass++;
        @(negedge clk);
        shr_rvalid = 1'b0;
        #1;
        n_checks++;
        if (gnt !== 3'b001) $display("FAIL full_resume: got %b want 001", gnt);
        else n_pass++;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_routing();
        do_reset();
        shr_gnt = 1'b1;
        req = 3'b100;
        #1;
        n_checks++;
        if (gnt !== 3'b100) $display("FAIL route_g2: got %b want 100", gnt);
        else n_pass++;
        @(negedge clk);
        req = 3'b001;
        #1;
        n_checks++;
        if (gnt !== 3'b001) $display("FAIL route_g0: got %b want 001", gnt);
        else n_pass++;
        @(negedge clk);
        req = 3'b000;
        shr_rvalid = 1'b1;
        shr_rdata = 32'hDEADBEEF;
        #1;
        n_checks++;
        if (rvalid !== 3'b100 || rdata[2] !== 32'hDEADBEEF || rdata[0] !== 32'h0 || rdata[1] !== 32'h0)
            $display("FAIL route_r2: got %b %h/%h/%h", rvalid, rdata[0], rdata[1], rdata[2]);
        else n_pass++;
        @(negedge clk);
        shr_rdata = 32'h12345678;
        #1;
        n_checks++;
        if (rvalid !== 3'b001 || rdata[0] !== 32'h12345678 || rdata[1] !== 32'h0 || rdata[2] !== 32'h0)
            $display("FAIL route_r0: got %b %h/%h/%h", rvalid, rdata[0], rdata[1], rdata[2]);
        else n_pass++;
        @(negedge clk);
        shr_rdata = 32'h0BAD_0BAD;
        #1;
        n_checks++;
        if (rvalid !== 3'b000 || (rdata[0] | rdata[1] | rdata[2]) !== 32'h0)
            $display("FAIL route_spurious: got %b %h/%h/%h", rvalid, rdata[0], rdata[1], rdata[2]);
        else n_pass++;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        shr_gnt = 1'b1;
        req = 3'b001;
        @(negedge clk);
        req = 3'b010;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
        shr_rvalid = 1'b1;
        shr_rdata = 32'hFEED_FACE;
        #1;
        n_checks++;
        if (rvalid !== 3'b000) $display("FAIL mid_spurious: got %b want 000", rvalid);
        else n_pass++;
        @(negedge clk);
        shr_rvalid = 1'b0;
        req = 3'b111;
        shr_gnt = 1'b1;
        #1;
        n_checks++;
        if (gnt !== 3'b001) $display("FAIL mid_rr: got %b want 001", gnt);
        else n_pass++;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_random();
        int q[$];
        int rr = 0, lsel = 0, es;
        bit locked = 0, ep, pop;
        bit pend[3] = '{0, 0, 0};
        logic [2:0] exp_g, exp_rv;
        logic [31:0] exp_rd;
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && $urandom_range(0, 2) != 0) begin
                    pend[i]  = 1;
                    addr[i]  = $urandom;
                    wdata[i] = $urandom;
                    be[i]    = 4'($urandom_range(0, 15));
                    we[i]    = ($urandom_range(0, 2) == 0);
                end
                req[i] = pend[i];
            end
            shr_gnt    = ($urandom_range(0, 3) != 0);
            shr_rvalid = (q.size() > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
            shr_rdata  = $urandom;

            if (locked) begin
                es = lsel;
                ep = req[lsel];
            end else begin
                ep = 0;
                es = rr;
                for (int k = 0; k < 3; k++) begin
                    int m = (rr + k) % 3;
                    if (!ep && req[m] && (we[m] || q.size() < DEPTH)) begin
                        ep = 1;
                        es = m;
                    end
                end
            end
            pop    = shr_rvalid && q.size() > 0;
            exp_g  = (ep && shr_gnt) ? 3'(1 << es) : 3'b000;
            exp_rv = pop ? 3'(1 << q[0]) : 3'b000;
            #1;
            n_checks++;
            if (shr_req !== ep || gnt !== exp_g)
                $display("FAIL rnd_gnt c%0d: got %b/%b want %b/%b", c, shr_req, gnt, ep, exp_g);
            else n_pass++;
            n_checks++;
            if ({shr_addr, shr_we, shr_be, shr_wdata} !== {addr[es], we[es], be[es], wdata[es]})
                $display("FAIL rnd_payload c%0d: got %h want %h (master %0d)", c, shr_addr, addr[es], es);
            else n_pass++;
            n_checks++;
            if (rvalid !== exp_rv) $display("FAIL rnd_rvalid c%0d: got %b want %b", c, rvalid, exp_rv);
            else n_pass++;
            for (int i = 0; i < 3; i++) begin
                exp_rd = (pop && q[0] == i) ? shr_rdata : 32'h0;
                n_checks++;
                if (rdata[i] !== exp_rd)
                    $display("FAIL rnd_rdata%0d c%0d: got %h want %h", i, c, rdata[i], exp_rd);
                else n_pass++;
            end
            if (pop) void'(q.pop_front());
            if (ep && shr_gnt) begin
                rr     = (es + 1) % 3;
                locked = 0;
                if (!we[es]) q.push_back(es);
                pend[es] = 0;
            end else if (ep) begin
                locked = 1;
                lsel   = es;
            end
            @(negedge clk);
        end
        clear_inputs();
    endtask

`ifdef OBI_ARB_STALL_CNT_EN
    task automatic test_stall_cnt();
        do_reset();
        req[2] = 1'b1;
        repeat (70000) @(negedge clk);
        #1;
        n_checks++;
        if (stall_cnt[47:32] !== 16'hFFFF || stall_cnt[31:0] !== 32'h0)
            $display("FAIL stall_sat: got %h want ffff00000000", stall_cnt);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_checks++;
        if (stall_cnt !== 48'h0) $display("FAIL stall_reset: got %h want 0", stall_cnt);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
        test_rotation();
        test_lock();
        test_fifo_full();
        test_routing();
        test_reset_mid();
        test_random();
`ifdef OBI_ARB_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
